// File: rtl/dp_pkg.sv
// rtl/dp_pkg.sv - opcodes and sequencer states for seq_bus_datapath
package dp_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SHL   = 4'd5;
  localparam logic [3:0] OP_SHR   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_MUL   = 4'd8;
  localparam logic [3:0] OP_LOAD  = 4'd9;
  localparam logic [3:0] OP_STORE = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RA,
    S_RB,
    S_WB,
    S_MEM
  } state_t;

  function automatic logic op_is_alu(input logic [3:0] op);
    return op <= OP_MUL;
  endfunction

endpackage

// File: rtl/dp_alu.sv
// rtl/dp_alu.sv - combinational ALU: Z = op(Y, bus), double-width for MUL
module dp_alu
  import dp_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] zhi,
  output logic [DATA_W-1:0] zlo
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0]     sh;
  logic [2*DATA_W-1:0] a_ext;
  logic [2*DATA_W-1:0] b_ext;

  assign sh = b[SH_W-1:0];
  // Low 2W bits of the product of sign-extended operands equal the signed product.
  assign a_ext = {{DATA_W{a[DATA_W-1]}}, a};
  assign b_ext = {{DATA_W{b[DATA_W-1]}}, b};

  always_comb begin
    zhi = '0;
    zlo = '0;
    case (op)
      OP_ADD:  zlo = a + b;
      OP_SUB:  zlo = a - b;
      OP_AND:  zlo = a & b;
      OP_OR:   zlo = a | b;
      OP_XOR:  zlo = a ^ b;
      OP_SHL:  zlo = a << sh;
      OP_SHR:  zlo = a >> sh;
      OP_SRA:  zlo = $signed(a) >>> sh;
      OP_MUL:  {zhi, zlo} = a_ext * b_ext;
      default: zlo = '0;
    endcase
  end

endmodule

// File: rtl/seq_bus_datapath.sv
// rtl/seq_bus_datapath.sv - single-bus datapath with its own micro-step sequencer
module seq_bus_datapath
  import dp_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter bit R0_ZERO  = 1'b0,
  localparam int REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic [REG_AW-1:0] cmd_ra,
  input  logic [REG_AW-1:0] cmd_rb,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_t              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [REG_AW-1:0]   rd_q, rd_d, ra_q, ra_d, rb_q, rb_d;
  logic [DATA_W-1:0]   y_q, y_d;
  logic [2*DATA_W-1:0] z_q, z_d;
  logic [DATA_W-1:0]   mar_q, mar_d, mdr_q, mdr_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];

  logic [DATA_W-1:0]   bus;
  logic [DATA_W-1:0]   alu_zhi, alu_zlo;
  logic                wr_en;

  function automatic logic [DATA_W-1:0] read_reg(input logic [REG_AW-1:0] idx);
    if (R0_ZERO && idx == '0) return '0;
    return regs_q[idx];
  endfunction

  dp_alu #(.DATA_W(DATA_W)) u_alu (
    .op  (op_q),
    .a   (y_q),
    .b   (bus),
    .zhi (alu_zhi),
    .zlo (alu_zlo)
  );

  // Single shared bus: exactly one source per micro-step.
  always_comb begin
    bus = '0;
    case (state_q)
      S_RA:    bus = read_reg(ra_q);
      S_RB:    bus = read_reg(rb_q);
      S_WB:    bus = (op_q == OP_LOAD) ? mdr_q : z_q[DATA_W-1:0];
      default: bus = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    y_d       = y_q;
    z_d       = z_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    wr_en     = 1'b0;
    cmd_ready = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d = cmd_op;
          rd_d = cmd_rd;
          ra_d = cmd_ra;
          rb_d = cmd_rb;
          if (op_is_alu(cmd_op) || cmd_op == OP_LOAD || cmd_op == OP_STORE)
            state_d = S_RA;
          else
            state_d = S_WB;
        end
      end
      S_RA: begin
        if (op_is_alu(op_q)) begin
          y_d     = bus;
          state_d = S_RB;
        end else begin
          mar_d   = bus;
          state_d = (op_q == OP_LOAD) ? S_MEM : S_RB;
        end
      end
      S_RB: begin
        if (op_is_alu(op_q)) begin
          z_d     = {alu_zhi, alu_zlo};
          state_d = S_WB;
        end else begin
          mdr_d   = bus;
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op_q == OP_STORE);
        if (mem_ack) begin
          if (op_q == OP_STORE) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        done    = 1'b1;
        state_d = S_IDLE;
        if (op_is_alu(op_q) || op_q == OP_LOAD) begin
          wr_en = 1'b1;
          if (op_q == OP_MUL) begin
            hi_d = z_q[2*DATA_W-1:DATA_W];
            lo_d = z_q[DATA_W-1:0];
          end
        end else begin
          err = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      y_q     <= '0;
      z_q     <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      y_q     <= y_d;
      z_q     <= z_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      if (wr_en && !(R0_ZERO && rd_q == '0)) regs_q[rd_q] <= bus;
    end
  end

  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_data  = read_reg(dbg_addr);

endmodule

// File: tb/tb_seq_bus_datapath.sv
// tb/tb_seq_bus_datapath.sv - bench for seq_bus_datapath, R0_ZERO=0 and R0_ZERO=1 side by side
module tb_seq_bus_datapath;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4;
  localparam logic [3:0] SHL = 4'd5, SHR = 4'd6, SRA = 4'd7, MUL = 4'd8;
  localparam logic [3:0] LOAD = 4'd9, STORE = 4'd10;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [3:0]  cmd_op, cmd_rd, cmd_ra, cmd_rb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [3:0]  dbg_addr;

  logic [1:0]  cmd_ready, done, err, mem_req, mem_we;
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata[2];
  logic [31:0] hi       [2];
  logic [31:0] lo       [2];
  logic [31:0] dbg_data [2];

  seq_bus_datapath #(.DATA_W(32), .NUM_REGS(16), .R0_ZERO(1'b0)) dut0 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .done(done[0]), .err(err[0]), .mem_req(mem_req[0]), .mem_we(mem_we[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .hi(hi[0]), .lo(lo[0]), .dbg_addr(dbg_addr), .dbg_data(dbg_data[0])
  );

  seq_bus_datapath #(.DATA_W(32), .NUM_REGS(16), .R0_ZERO(1'b1)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .done(done[1]), .err(err[1]), .mem_req(mem_req[1]), .mem_we(mem_we[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .hi(hi[1]), .lo(lo[1]), .dbg_addr(dbg_addr), .dbg_data(dbg_data[1])
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Architectural model: register contents per instance, HI/LO, per-cycle expectations.
  logic [31:0] m_regs[2][16];
  logic [31:0] m_hi[2], m_lo[2];
  logic [31:0] exp_addr[2], exp_wdata[2];
  logic        exp_ready, exp_done, exp_err, exp_req, exp_we;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %h want %h", nm, k, $time, act, exp_v);
    end
  endtask

  function automatic logic [31:0] mreg(input int k, input int i);
    return (k == 1 && i == 0) ? 32'h0 : m_regs[k][i];
  endfunction

  task automatic mwrite(input int k, input int rd, input logic [31:0] v);
    if (!(k == 1 && rd == 0)) m_regs[k][rd] = v;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) m_regs[k][i] = 32'h0;
      m_hi[k] = 32'h0;
      m_lo[k] = 32'h0;
    end
  endtask

  function automatic void alu_m(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] rh, output logic [31:0] rl);
    int     sh;
    longint p;
    sh = int'(b[4:0]);
    rh = 32'h0;
    rl = 32'h0;
    case (op)
      ADD:  rl = a + b;
      SUB:  rl = a - b;
      AND_: rl = a & b;
      OR_:  rl = a | b;
      XOR_: rl = a ^ b;
      SHL:  rl = a << sh;
      SHR:  rl = a >> sh;
      SRA:  rl = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      MUL: begin
        p  = longint'($signed(a)) * longint'($signed(b));
        rh = p[63:32];
        rl = p[31:0];
      end
      default: rl = 32'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("cmd_ready", k, cmd_ready[k], exp_ready);
        chk("done", k, done[k], exp_done);
        if (exp_done) chk("err", k, err[k], exp_err);
        chk("mem_req", k, mem_req[k], exp_req);
        if (exp_req) begin
          chk("mem_we", k, mem_we[k], exp_we);
          chk("mem_addr", k, mem_addr[k], exp_addr[k]);
          if (exp_we) chk("mem_wdata", k, mem_wdata[k], exp_wdata[k]);
        end
        chk("hi", k, hi[k], m_hi[k]);
        chk("lo", k, lo[k], m_lo[k]);
        chk("dbg_data", k, dbg_data[k], mreg(k, int'(dbg_addr)));
      end
    end
  end

  task automatic set_idle();
    exp_ready = 1'b1; exp_done = 1'b0; exp_err = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
  endtask

  // One clock: publish expectations, drive memory side, scramble inputs the DUT must ignore.
  task automatic step(input bit rdy, input bit dn, input bit er, input bit rq, input bit we,
                      input bit ack, input logic [31:0] rdata);
    exp_ready = rdy; exp_done = dn; exp_err = er; exp_req = rq; exp_we = we;
    mem_ack   = ack;
    mem_rdata = rdata;
    if (!rdy) begin
      cmd_valid = 1'b1;
      cmd_op = 4'($urandom); cmd_rd = 4'($urandom); cmd_ra = 4'($urandom); cmd_rb = 4'($urandom);
      if (!rq) begin
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
    dbg_addr = dbg_addr + 4'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [3:0] op, input int rd, input int ra, input int rb,
                        input int waits, input logic [31:0] rdata);
    logic [31:0] a[2], b[2], rh, rl;
    for (int k = 0; k < 2; k++) begin
      a[k] = mreg(k, ra);
      b[k] = mreg(k, rb);
      exp_addr[k]  = a[k];
      exp_wdata[k] = b[k];
    end
    cmd_valid = 1'b1;
    cmd_op = op; cmd_rd = 4'(rd); cmd_ra = 4'(ra); cmd_rb = 4'(rb);
    step(1, 0, 0, 0, 0, 0, 32'h0);
    if (op <= MUL) begin
      step(0, 0, 0, 0, 0, 0, 32'h0);
      step(0, 0, 0, 0, 0, 0, 32'h0);
      step(0, 1, 0, 0, 0, 0, 32'h0);
      for (int k = 0; k < 2; k++) begin
        alu_m(op, a[k], b[k], rh, rl);
        mwrite(k, rd, rl);
        if (op == MUL) begin
          m_hi[k] = rh;
          m_lo[k] = rl;
        end
      end
    end else if (op == LOAD) begin
      step(0, 0, 0, 0, 0, 0, 32'h0);
      for (int w = 0; w < waits; w++) step(0, 0, 0, 1, 0, 0, $urandom);
      step(0, 0, 0, 1, 0, 1, rdata);
      step(0, 1, 0, 0, 0, 0, 32'h0);
      for (int k = 0; k < 2; k++) mwrite(k, rd, rdata);
    end else if (op == STORE) begin
      step(0, 0, 0, 0, 0, 0, 32'h0);
      step(0, 0, 0, 0, 0, 0, 32'h0);
      for (int w = 0; w < waits; w++) step(0, 0, 0, 1, 1, 0, 32'h0);
      step(0, 1, 0, 1, 1, 1, 32'h0);
    end else begin
      step(0, 1, 1, 0, 0, 0, 32'h0);
    end
    cmd_valid = 1'b0;
    mem_ack   = 1'b0;
    set_idle();
  endtask

  task automatic lit(input string nm, input int k, input int idx, input logic [31:0] v);
    dbg_addr = 4'(idx);
    #1;
    chk(nm, k, dbg_data[k], v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 4'h0; cmd_rd = 4'h0; cmd_ra = 4'h0; cmd_rb = 4'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0; dbg_addr = 4'h0;
    model_reset();
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_mem_req", k, mem_req[k], 1'b0);
      chk("rst_done", k, done[k], 1'b0);
    end
    reset = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 0, 0, 32'h0);

    do_cmd(LOAD, 1, 0, 0, 2, 32'h0000_0005);
    lit("load_r1", 0, 1, 32'h0000_0005);
    do_cmd(LOAD, 2, 0, 0, 0, 32'h0000_0007);
    do_cmd(ADD, 3, 1, 2, 0, 32'h0);
    lit("add_r3", 0, 3, 32'h0000_000C);
    do_cmd(SUB, 4, 1, 2, 0, 32'h0);
    lit("sub_r4", 0, 4, 32'hFFFF_FFFE);

    do_cmd(LOAD, 1, 0, 0, 1, 32'hFFFF_FFFE);
    do_cmd(LOAD, 2, 0, 0, 0, 32'h0000_0003);
    do_cmd(MUL, 5, 1, 2, 0, 32'h0);
    lit("mul_r5", 0, 5, 32'hFFFF_FFFA);
    chk("mul_hi", 0, hi[0], 32'hFFFF_FFFF);
    chk("mul_lo", 0, lo[0], 32'hFFFF_FFFA);

    do_cmd(LOAD, 2, 0, 0, 0, 32'h0000_0001);
    do_cmd(SRA, 6, 1, 2, 0, 32'h0);
    lit("sra_r6", 0, 6, 32'hFFFF_FFFF);
    do_cmd(SHR, 7, 1, 2, 0, 32'h0);
    lit("shr_r7", 0, 7, 32'h7FFF_FFFF);
    do_cmd(SHL, 8, 1, 2, 0, 32'h0);
    do_cmd(AND_, 9, 1, 2, 0, 32'h0);
    do_cmd(OR_, 10, 1, 2, 0, 32'h0);
    do_cmd(XOR_, 11, 1, 2, 0, 32'h0);
    lit("shl_r8", 0, 8, 32'hFFFF_FFFC);

    do_cmd(LOAD, 12, 0, 0, 0, 32'h0000_0100);
    do_cmd(LOAD, 13, 0, 0, 2, 32'hDEAD_BEEF);
    do_cmd(STORE, 0, 12, 13, 0, 32'h0);
    do_cmd(STORE, 0, 13, 12, 3, 32'h0);
    lit("store_r13", 0, 13, 32'hDEAD_BEEF);

    do_cmd(4'hF, 3, 1, 2, 0, 32'h0);
    do_cmd(4'hB, 4, 1, 2, 0, 32'h0);
    lit("illegal_r3", 0, 3, 32'h0000_000C);

    do_cmd(ADD, 0, 1, 2, 0, 32'h0);
    lit("r0_plain", 0, 0, 32'hFFFF_FFFF);
    lit("r0_zero", 1, 0, 32'h0000_0000);
    do_cmd(MUL, 0, 1, 2, 0, 32'h0);
    chk("r0z_mul_lo", 1, lo[1], 32'hFFFF_FFFE);
    do_cmd(ADD, 1, 1, 1, 0, 32'h0);
    lit("rd_eq_ra", 0, 1, 32'hFFFF_FFFC);
    do_cmd(SUB, 14, 0, 2, 0, 32'h0);
    lit("sub_r0src", 0, 14, 32'hFFFF_FFFD);
    lit("sub_r0src_z", 1, 14, 32'hFFFF_FFFF);

    // Abandon a LOAD while its memory request is outstanding.
    for (int k = 0; k < 2; k++) exp_addr[k] = mreg(k, 12);
    cmd_valid = 1'b1;
    cmd_op = LOAD; cmd_rd = 4'd3; cmd_ra = 4'd12; cmd_rb = 4'd0;
    step(1, 0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0);
    cmd_valid = 1'b0;
    mem_ack = 1'b0;
    exp_ready = 1'b0; exp_done = 1'b0; exp_req = 1'b1; exp_we = 1'b0;
    @(negedge clk);
    #2;
    chk_en = 1'b0;
    reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_async_req", k, mem_req[k], 1'b0);
      chk("rst_async_done", k, done[k], 1'b0);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    set_idle();
    chk_en = 1'b1;
    for (int i = 0; i < 18; i++) step(1, 0, 0, 0, 0, 1, 32'hBAD0_BAD0);
    mem_ack = 1'b0;
    lit("post_rst_r3", 0, 3, 32'h0000_0000);
    chk("post_rst_hi", 0, hi[0], 32'h0);
    chk("post_rst_ready", 0, cmd_ready[0], 1'b1);

    do_cmd(LOAD, 5, 0, 0, 0, 32'h0000_0009);
    do_cmd(ADD, 6, 5, 5, 0, 32'h0);
    lit("post_rst_add", 0, 6, 32'h0000_0012);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
